// File: rtl/led_serial_rx_if.sv
// Bus bundle for led_serial_rx: serial LED-chain inputs, the buffered word
// stream with its ready/valid handshake, per-frame status and a debug view
// of the receiver FSM.
//
// Handshake: a word moves on every i_clk edge where o_valid and i_ready are
// both high. While o_valid is high and i_ready is low, o_data and o_valid
// hold their values. i_ready may change freely and does not depend on o_valid.
interface led_serial_rx_if #(
  parameter int P_WORD_BITS = 12,
  parameter int P_MAX_WORDS = 288
);
  logic                             i_sclk;
  logic                             i_sdai;
  logic                             i_slat;
  logic [P_WORD_BITS-1:0]           o_data;
  logic                             o_valid;
  logic                             i_ready;
  logic                             o_frame;
  logic [$clog2(P_MAX_WORDS+1)-1:0] o_word_count;
  logic                             o_partial;
  logic                             o_overflow;
  logic [1:0]                       dbg_state;

  // Receiver side: consumes serial inputs and i_ready, produces the rest.
  modport master (
    input  i_sclk, i_sdai, i_slat, i_ready,
    output o_data, o_valid, o_frame, o_word_count, o_partial, o_overflow,
           dbg_state
  );

  // Environment side: LED-chain transmitter plus word consumer.
  modport slave (
    output i_sclk, i_sdai, i_slat, i_ready,
    input  o_data, o_valid, o_frame, o_word_count, o_partial, o_overflow,
           dbg_state
  );
endinterface

// File: rtl/led_serial_rx.sv
// led_serial_rx: deserialises an LED-chain grey-scale stream (MSB first,
// sampled on i_sclk rising edges seen in the i_clk domain) into words,
// buffers them in a small FIFO behind a ready/valid port and reports
// per-frame word count / leftover status on each i_slat rising edge.
// Optional macro LED_SERIAL_RX_SYNC_EN inserts a two-flop synchronizer on
// i_sclk, i_sdai and i_slat for asynchronous sources (+2 cycles latency).
module led_serial_rx #(
  parameter int P_WORD_BITS  = 12,
  parameter int P_FIFO_DEPTH = 4,
  parameter int P_MAX_WORDS  = 288
) (
  input  logic         i_clk,
  input  logic         i_rst,
  led_serial_rx_if.master bus
);
  localparam int CW = $clog2(P_MAX_WORDS + 1);
  localparam int BW = $clog2(P_WORD_BITS + 1);
  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(P_WORD_BITS - 1);
  localparam logic [CW-1:0] MAX_WORDS = CW'(P_MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t state, state_nxt;

  // raw_in packs {slat, sdai, sclk} ahead of the input stage
  logic [2:0] raw_in;

`ifdef LED_SERIAL_RX_SYNC_EN
  logic [2:0] sync_meta, sync_out;

  // two-flop synchronizer for asynchronous LED-chain inputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= {bus.i_slat, bus.i_sdai, bus.i_sclk};
      sync_out  <= sync_meta;
    end
  end

  assign raw_in = sync_out;
`else
  assign raw_in = {bus.i_slat, bus.i_sdai, bus.i_sclk};
`endif

  logic [2:0] in_q;
  logic       sclk_prev, slat_prev;
  logic       sclk_rise, slat_rise;

  // input stage plus one-cycle history for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_q      <= '0;
      sclk_prev <= 1'b0;
      slat_prev <= 1'b0;
    end else begin
      in_q      <= raw_in;
      sclk_prev <= in_q[0];
      slat_prev <= in_q[2];
    end
  end

  assign sclk_rise = in_q[0] & ~sclk_prev;
  assign slat_rise = in_q[2] & ~slat_prev;

  // ---------------------------------------------------------------- datapath
  logic [P_WORD_BITS-1:0] shreg, shift_nxt;
  logic [BW-1:0]          bit_cnt;
  logic [CW-1:0]          word_cnt, word_cnt_inc, cap_word_cnt;
  logic                   word_done, cap_partial;
  logic [CW-1:0]          word_count_q;
  logic                   partial_q;

  assign shift_nxt    = {shreg[P_WORD_BITS-2:0], in_q[1]};
  assign word_done    = sclk_rise && (bit_cnt == LAST_BIT);
  assign word_cnt_inc = (word_cnt == MAX_WORDS) ? word_cnt : word_cnt + 1'b1;
  // frame status includes a bit whose edge coincides with the latch edge
  assign cap_word_cnt = word_done ? word_cnt_inc : word_cnt;
  assign cap_partial  = sclk_rise ? (bit_cnt != LAST_BIT) : (bit_cnt != '0);

  // shift register, bit/word counters and latched frame status
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      word_count_q <= '0;
      partial_q    <= 1'b0;
    end else begin
      if (sclk_rise) shreg <= shift_nxt;
      if (state == S_REPORT) begin
        // leftover bits are discarded; an edge in this cycle starts the next frame
        bit_cnt  <= sclk_rise ? BW'(1) : '0;
        word_cnt <= '0;
      end else if (sclk_rise) begin
        if (word_done) begin
          bit_cnt  <= '0;
          word_cnt <= word_cnt_inc;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (slat_rise) begin
        word_count_q <= cap_word_cnt;
        partial_q    <= cap_partial;
      end
    end
  end

  // -------------------------------------------------------------------- FIFO
  logic [P_WORD_BITS-1:0] mem [P_FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   fifo_empty, fifo_full, pop, push_ok, drop;
  logic                   overflow_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && bus.i_ready;
  // a pop in the same cycle frees the slot for a push into a full FIFO
  assign push_ok    = word_done && (!fifo_full || pop);
  assign drop       = word_done && fifo_full && !pop;

  // word buffer with sticky overflow flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < P_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= shift_nxt;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop)  rd_ptr     <= rd_ptr + 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------- FSM
  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state and frame pulse; a latch edge wins from any state
  always_comb begin
    state_nxt   = state;
    bus.o_frame = 1'b0;
    case (state)
      S_IDLE:   if (sclk_rise) state_nxt = S_SHIFT;
      S_SHIFT:  state_nxt = S_SHIFT;
      S_REPORT: begin
        bus.o_frame = 1'b1;
        state_nxt   = sclk_rise ? S_SHIFT : S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
    if (slat_rise) state_nxt = S_REPORT;
  end

  assign bus.o_valid      = !fifo_empty;
  assign bus.o_data       = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.o_word_count = word_count_q;
  assign bus.o_partial    = partial_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_led_serial_rx.sv
// Bench for led_serial_rx: serial stimulus with a behavioural model that
// turns the driven bit stream into expected words and frame reports.
module tb_led_serial_rx;
  localparam int W     = 12;
  localparam int DEPTH = 4;
  localparam int MAXW  = 288;
  localparam int CW    = $clog2(MAXW + 1);

  logic i_clk = 1'b0;
  logic i_rst;

  led_serial_rx_if #(.P_WORD_BITS(W), .P_MAX_WORDS(MAXW)) bus ();

  led_serial_rx #(
    .P_WORD_BITS(W), .P_FIFO_DEPTH(DEPTH), .P_MAX_WORDS(MAXW)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_beats = 0;
  int n_frames = 0;
  int ready_mode = 0;  // 0: never ready, 1: always ready, 2: random

  // scoreboard queues: expected words and expected frames {partial, count}
  logic [W-1:0]  exp_q[$];
  logic [CW:0]   frm_q[$];

  // model state for the frame in progress
  int           m_nbits = 0;
  int           m_words = 0;
  logic [W-1:0] m_word  = '0;
  logic         m_ov    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    n_cmp++;
    if (obs !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // ---------------------------------------------------------- model
  task automatic model_bit(input logic b);
    m_word = {m_word[W-2:0], b};
    m_nbits++;
    if (m_nbits == W) begin
      m_nbits = 0;
      m_words++;
      if (exp_q.size() >= DEPTH) m_ov = 1'b1;
      else exp_q.push_back(m_word);
      m_word = '0;
    end
  endtask

  task automatic model_latch();
    int cnt;
    cnt = (m_words > MAXW) ? MAXW : m_words;
    frm_q.push_back({(m_nbits != 0), CW'(cnt)});
    m_words = 0;
    m_nbits = 0;
    m_word  = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    frm_q.delete();
    m_nbits = 0;
    m_words = 0;
    m_word  = '0;
    m_ov    = 1'b0;
  endtask

  // ---------------------------------------------------------- drivers
  task automatic send_bit(input logic b);
    bus.i_sdai = b;
    bus.i_sclk = 1'b1;
    model_bit(b);
    tick(2);
    bus.i_sclk = 1'b0;
    tick(2);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic latch();
    bus.i_slat = 1'b1;
    model_latch();
    tick(2);
    bus.i_slat = 1'b0;
    tick(2);
  endtask

  // sclk and slat rise together; the bit belongs to the ending frame
  task automatic send_bit_with_latch(input logic b);
    bus.i_sdai = b;
    bus.i_sclk = 1'b1;
    bus.i_slat = 1'b1;
    model_bit(b);
    model_latch();
    tick(2);
    bus.i_sclk = 1'b0;
    bus.i_slat = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    bus.i_sclk = 1'b0;
    bus.i_slat = 1'b0;
    i_rst = 1'b1;
    model_reset();
    tick(2);
    i_rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || frm_q.size() != 0) && n < 4000) begin
      tick(1);
      n++;
    end
    check("drain_pending", 32'(exp_q.size() + frm_q.size()), 32'd0);
    tick(2);
  endtask

  // consumer ready pattern
  initial begin
    bus.i_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      bus.i_ready = (ready_mode == 1) ? 1'b1 :
                    (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // monitor: word beats, handshake hold, frame reports
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(bus.o_valid), 32'd1);
        check("hold_data", 32'(bus.o_data), 32'(prev_data));
      end
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) check("spurious_valid", 32'(bus.o_valid), 32'd0);
        else begin
          check("word", 32'(bus.o_data), 32'(exp_q.pop_front()));
          n_beats++;
        end
      end
      if (bus.o_frame) begin
        if (frm_q.size() == 0) check("spurious_frame", 32'(bus.o_frame), 32'd0);
        else begin
          logic [CW:0] f;
          f = frm_q.pop_front();
          check("frame_count", 32'(bus.o_word_count), 32'(f[CW-1:0]));
          check("frame_partial", 32'(bus.o_partial), 32'(f[CW]));
          n_frames++;
        end
      end
      prev_hold = bus.o_valid && !bus.i_ready;
      prev_data = bus.o_data;
    end
  end

  // ---------------------------------------------------------- main sequence
  initial begin
    int b0, f0, nb;
    bus.i_sclk = 1'b0;
    bus.i_sdai = 1'b0;
    bus.i_slat = 1'b0;
    i_rst = 1'b1;
    tick(3);
    i_rst = 1'b0;
    tick(1);
    check("rst_valid",    32'(bus.o_valid),      32'd0);
    check("rst_data",     32'(bus.o_data),       32'd0);
    check("rst_frame",    32'(bus.o_frame),      32'd0);
    check("rst_count",    32'(bus.o_word_count), 32'd0);
    check("rst_partial",  32'(bus.o_partial),    32'd0);
    check("rst_overflow", 32'(bus.o_overflow),   32'd0);

    // single word 0xA5C
    ready_mode = 1;
    b0 = n_beats;
    send_word(12'hA5C);
    wait_drain();
    check("a5c_beats", 32'(n_beats - b0), 32'd1);

    // 24 random words then latch, random consumer
    ready_mode = 2;
    f0 = n_frames;
    repeat (24) send_word(W'($urandom));
    latch();
    wait_drain();
    check("w24_frames", 32'(n_frames - f0), 32'd1);

    // 30 bits: two words plus six leftover bits
    b0 = n_beats;
    repeat (30) send_bit(1'($urandom_range(0, 1)));
    latch();
    wait_drain();
    check("b30_beats", 32'(n_beats - b0), 32'd2);

    // 12th edge coincident with latch
    ready_mode = 1;
    b0 = n_beats;
    send_word_prefix: for (int i = W - 1; i >= 1; i--) send_bit(1'(12'h6B1 >> i));
    send_bit_with_latch(1'b1);
    wait_drain();
    check("coinc_beats", 32'(n_beats - b0), 32'd1);

    // latch with no bits since last latch
    latch();
    wait_drain();

    // overflow: consumer stalled, five words
    do_reset();
    ready_mode = 0;
    tick(2);
    for (int i = 0; i < 5; i++) send_word(W'(12'h101 * (i + 1)));
    tick(4);
    check("ovf_set", 32'(bus.o_overflow), 32'(m_ov));
    check("ovf_valid", 32'(bus.o_valid), 32'd1);
    latch();
    ready_mode = 1;
    wait_drain();
    check("ovf_sticky", 32'(bus.o_overflow), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(bus.o_overflow), 32'd0);

    // reset in the middle of a word
    repeat (7) send_bit(1'b1);
    do_reset();
    b0 = n_beats;
    send_word(12'h123);
    wait_drain();
    check("rst_mid_beats", 32'(n_beats - b0), 32'd1);
    check("rst_mid_ovf",   32'(bus.o_overflow),   32'd0);
    check("rst_mid_part",  32'(bus.o_partial),    32'd0);
    check("rst_mid_count", 32'(bus.o_word_count), 32'd0);
    check("rst_mid_valid", 32'(bus.o_valid),      32'd0);

    // word-count saturation
    repeat (MAXW + 2) send_word(W'($urandom));
    latch();
    wait_drain();

    // random frames
    ready_mode = 2;
    for (int k = 0; k < 6; k++) begin
      nb = $urandom_range(0, 50);
      for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) send_bit_with_latch(1'($urandom_range(0, 1)));
      else latch();
    end
    wait_drain();
    check("final_ovf", 32'(bus.o_overflow), 32'(m_ov));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/led_serial_rx.md
LED_SERIAL_RX -- requirements
Module: led_serial_rx

Interface
REQ-001 SHALL have parameter P_WORD_BITS, default 12, bits per grey-scale channel word.
REQ-002 SHALL have parameter P_FIFO_DEPTH, default 4, output word buffer depth (power of two, >=2).
REQ-003 SHALL have parameter P_MAX_WORDS, default 288, word-count saturation value per frame.
REQ-004 SHALL have ports: i_clk in 1, system clock, sole clock domain.
REQ-005 SHALL have ports: i_rst in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: i_sclk in 1, serial shift clock from LED-chain transmitter.
REQ-007 SHALL have ports: i_sdai in 1, serial data, MSB first.
REQ-008 SHALL have ports: i_slat in 1, latch strobe ending a frame.
REQ-009 SHALL have ports: o_data out P_WORD_BITS, buffered word at FIFO head.
REQ-010 SHALL have ports: o_valid out 1 and i_ready in 1, ready/valid output handshake.
REQ-011 SHALL have ports: o_frame out 1, one-cycle pulse on accepted latch.
REQ-012 SHALL have ports: o_word_count out $clog2(P_MAX_WORDS+1), complete words in the ended frame.
REQ-013 SHALL have ports: o_partial out 1, frame ended with nonzero leftover bits; o_overflow out 1, sticky word-drop flag.

Function
REQ-014 SHALL sample i_sclk, i_sdai, i_slat into an input stage every i_clk; rising edge = current 1, previous 0.
REQ-015 SHALL, on i_sclk rising edge, shift the i_sdai value from the same input stage into the shift register LSB and increment the bit counter.
REQ-016 SHALL, when the bit counter reaches P_WORD_BITS, push the word into the FIFO, clear the bit counter, increment the frame word counter (saturating at P_MAX_WORDS).
REQ-017 SHALL assert o_valid with the new word the cycle after the completing edge is detected, if the FIFO was empty.
REQ-018 SHALL pop the FIFO when o_valid and i_ready are both high; o_data/o_valid stable while o_valid=1 and i_ready=0.
REQ-019 SHALL, when a word completes with the FIFO full and no pop that cycle, drop the word, set o_overflow, still count it in the frame word counter.
REQ-020 SHALL, with push and pop in the same cycle on a full FIFO, accept the push (no overflow).
REQ-021 SHALL use FSM S_IDLE (no bits since latch/reset), S_SHIFT (>=1 bit received), S_REPORT (one cycle, drives o_frame).
REQ-022 SHALL transition S_IDLE->S_SHIFT on first sclk edge; any state->S_REPORT on i_slat rising edge; S_REPORT->S_IDLE, or ->S_SHIFT if an sclk edge occurs in S_REPORT.
REQ-023 SHALL, in S_REPORT, pulse o_frame, present o_word_count and o_partial (held until next S_REPORT), then clear bit and word counters.
REQ-024 SHALL, on simultaneous sclk and slat edges, shift that bit first, then evaluate the latch (bit included in count/partial).
REQ-025 SHALL report o_frame with o_word_count=0, o_partial=0 for a latch in S_IDLE.
REQ-026 SHALL discard partial-word bits at latch; they never reach the FIFO.
REQ-027 SHALL require i_sclk high and low each >=2 i_clk cycles; faster inputs are undefined.

Reset
REQ-028 SHALL, on i_rst=1 at an i_clk edge, clear FIFO, shift register, counters, input stage; state S_IDLE.
REQ-029 SHALL reset outputs: o_valid=0, o_data=0, o_frame=0, o_word_count=0, o_partial=0, o_overflow=0.
REQ-030 SHALL abandon any in-progress word or frame on reset mid-operation; no word emitted from pre-reset bits.

Configuration
REQ-031 SHALL honour macro LED_SERIAL_RX_SYNC_EN: defined -> two-flop synchronizer on each of i_sclk, i_sdai, i_slat ahead of the input stage, adding 2 cycles of latency.
REQ-032 SHALL, without LED_SERIAL_RX_SYNC_EN, feed the inputs directly to the input stage (inputs synchronous to i_clk); all other behaviour identical.

Verification
REQ-033 SHALL cover: 12 edges of 0xA5C MSB first, i_ready=1 -> one o_valid beat, o_data=0xA5C.
REQ-034 SHALL cover: 24 words, then latch -> o_frame pulse, o_word_count=24, o_partial=0.
REQ-035 SHALL cover: 30 bits, then latch -> 2 words out, o_word_count=2, o_partial=1, leftover 6 bits never emitted.
REQ-036 SHALL cover: i_ready=0, 5 words -> first 4 buffered in order, 5th dropped, o_overflow=1 until reset.
REQ-037 SHALL cover: 12th sclk edge coincident with slat edge -> word emitted, o_word_count=1, o_partial=0.
REQ-038 SHALL cover: i_rst pulse after 7 bits, then 12 bits of 0x123 -> single word 0x123, all flags 0.
